// File: rtl/sbox_ti_seq_pkg.sv
// Shared types for the TI S-box round sequencer: FSM states, share vector, counter width.
// Optional remasking is enabled by SBOX_TI_REMASK_EN (see sbox_ti_share_reg).
package sbox_ti_seq_pkg;

  localparam int CNT_W      = 3;
  localparam int NSHARE_DEF = 3;
  localparam int W_DEF      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } seq_state_e;

  typedef logic [NSHARE_DEF*W_DEF-1:0] share_vec_t;

endpackage

// File: rtl/sbox_ti_share_reg.sv
// Share register between TI rounds: clear/load/capture mux plus optional remask network.
// Define SBOX_TI_REMASK_EN to add the i_rnd port and refresh the shares on every capture.
module sbox_ti_share_reg
  import sbox_ti_seq_pkg::*;
#(
  parameter int NSHARE = 3,
  parameter int W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_load,
  input  logic                  i_capture,
  input  logic [NSHARE*W-1:0]   i_loadShares,
  input  logic [NSHARE*W-1:0]   i_stageOut,
`ifdef SBOX_TI_REMASK_EN
  input  logic [(NSHARE-1)*W-1:0] i_rnd,
`endif
  output logic [NSHARE*W-1:0]   o_shares
);

  logic [NSHARE*W-1:0] r_shares;
  logic [NSHARE*W-1:0] w_captureVal;

`ifdef SBOX_TI_REMASK_EN
  logic [W-1:0] w_rndSum;

  // Each fresh mask is added to one share and also to the last one, so the XOR of all shares is unchanged.
  always_comb begin
    w_rndSum     = '0;
    w_captureVal = i_stageOut;
    for (int i = 0; i < NSHARE-1; i++) begin
      w_captureVal[i*W +: W] = i_stageOut[i*W +: W] ^ i_rnd[i*W +: W];
      w_rndSum               = w_rndSum ^ i_rnd[i*W +: W];
    end
    w_captureVal[(NSHARE-1)*W +: W] = i_stageOut[(NSHARE-1)*W +: W] ^ w_rndSum;
  end
`else
  assign w_captureVal = i_stageOut;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_shares <= '0;
    else if (i_clear)   r_shares <= '0;
    else if (i_load)    r_shares <= i_loadShares;
    else if (i_capture) r_shares <= w_captureVal;
  end

  assign o_shares = r_shares;

endmodule

// File: rtl/sbox_ti_round_sequencer.sv
// Sequences a registered multi-round TI S-box over a time-multiplexed external round datapath.
// Define SBOX_TI_REMASK_EN to add the rnd port used for per-round share remasking.
module sbox_ti_round_sequencer
  import sbox_ti_seq_pkg::*;
#(
  parameter int NSHARE = 3,
  parameter int W      = 4,
  parameter int ROUNDS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NSHARE*W-1:0]   in_shares,
  output logic [NSHARE*W-1:0]   stage_in,
  output logic [CNT_W-1:0]      stage_round,
  input  logic [NSHARE*W-1:0]   stage_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NSHARE*W-1:0]   out_shares
`ifdef SBOX_TI_REMASK_EN
  ,
  input  logic [(NSHARE-1)*W-1:0] rnd
`endif
);

  localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(ROUNDS);

  seq_state_e          r_state;
  seq_state_e          w_nextState;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_nextCnt;
  logic                w_load;
  logic                w_capture;
  logic                w_clear;
  logic [NSHARE*W-1:0] w_shares;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
    end
  end

  // flush is applied last so it overrides any load, capture or state change decided above.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_load      = 1'b1;
          w_nextState = RUN;
          w_nextCnt   = CNT_W'(1);
        end
      end
      RUN: begin
        w_capture = 1'b1;
        if (r_cnt == LAST_ROUND) w_nextState = HOLD;
        else                     w_nextCnt   = r_cnt + CNT_W'(1);
      end
      HOLD: begin
        if (out_ready) begin
          w_nextState = IDLE;
          w_nextCnt   = '0;
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextCnt   = '0;
      end
    endcase
    if (flush) begin
      w_nextState = IDLE;
      w_nextCnt   = '0;
      w_load      = 1'b0;
      w_capture   = 1'b0;
      w_clear     = 1'b1;
    end
  end

  sbox_ti_share_reg #(
    .NSHARE (NSHARE),
    .W      (W)
  ) u_shareReg (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_clear),
    .i_load       (w_load),
    .i_capture    (w_capture),
    .i_loadShares (in_shares),
    .i_stageOut   (stage_out),
`ifdef SBOX_TI_REMASK_EN
    .i_rnd        (rnd),
`endif
    .o_shares     (w_shares)
  );

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == HOLD);
  assign stage_round = (r_state == RUN) ? r_cnt : '0;
  assign stage_in    = w_shares;
  assign out_shares  = w_shares;

endmodule

// File: tb/tb_sbox_ti_round_sequencer.sv
// Self-checking bench for sbox_ti_round_sequencer with an XOR-by-round stub as the round logic.
// Build with SBOX_TI_REMASK_EN defined to also exercise the remask path.
module tb_sbox_ti_round_sequencer;
  import sbox_ti_seq_pkg::*;

  localparam int NS     = 3;
  localparam int W      = 4;
  localparam int ROUNDS = 2;
  localparam int SW     = NS*W;
  localparam int RW     = (NS-1)*W;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_shares;
  logic [SW-1:0] stage_in;
  logic [2:0]    stage_round;
  logic [SW-1:0] stage_out;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_shares;
  logic [RW-1:0] rnd;
  logic [W-1:0]  roundW;
  bit            randRnd;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  assign roundW    = W'(stage_round);
  assign stage_out = stage_in ^ {NS{roundW}};

  sbox_ti_round_sequencer #(.NSHARE(NS), .W(W), .ROUNDS(ROUNDS)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_shares   (in_shares),
    .stage_in    (stage_in),
    .stage_round (stage_round),
    .stage_out   (stage_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
`ifdef SBOX_TI_REMASK_EN
    .rnd         (rnd),
`endif
    .out_shares  (out_shares)
  );

  // Reference: round r XORs r into every share, so the result is the input XOR each round number.
  function automatic logic [SW-1:0] model_eval(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    r = v;
    for (int rd = 1; rd <= ROUNDS; rd++)
      for (int s = 0; s < NS; s++)
        r[s*W +: W] = r[s*W +: W] ^ W'(rd);
    return r;
  endfunction

  function automatic logic [W-1:0] fold(input logic [SW-1:0] v);
    logic [W-1:0] f;
    f = '0;
    for (int s = 0; s < NS; s++) f = f ^ v[s*W +: W];
    return f;
  endfunction

  // One full evaluation from IDLE with out_ready held high; ok=0 if out_valid never shows up.
  task automatic do_eval(input logic [SW-1:0] vin, output logic [SW-1:0] vout, output bit ok);
    ok   = 1'b0;
    vout = '0;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_shares = vin;
    if (randRnd) rnd = RW'($urandom);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < ROUNDS+4; k++) begin
      if (out_valid) begin
        vout = out_shares;
        ok   = 1'b1;
        break;
      end
      if (randRnd) rnd = RW'($urandom);
      @(negedge clk);
    end
    if (ok) @(negedge clk);
  endtask

  task automatic test_reset();
    #3;
    testsRun++; if (in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    testsRun++; if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    testsRun++; if (stage_round !== 3'd0) begin testsFailed++; $display("[TB] FAIL reset_stage_round: got %0d want 0", stage_round); end
    testsRun++; if (out_shares !== '0) begin testsFailed++; $display("[TB] FAIL reset_out_shares: got %h want 000", out_shares); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [SW-1:0] vin;
    logic [SW-1:0] exp;
    vin = 12'h123;
    exp = model_eval(vin);
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_shares = vin;
    @(negedge clk);
    in_valid = 1'b0; in_shares = '0;
    testsRun++; if (stage_round !== 3'd1) begin testsFailed++; $display("[TB] FAIL single_round1: got %0d want 1", stage_round); end
    testsRun++; if (stage_in !== vin) begin testsFailed++; $display("[TB] FAIL single_loaded: got %h want %h", stage_in, vin); end
    testsRun++; if (in_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_busy: got %b want 0", in_ready); end
    @(negedge clk);
    testsRun++; if (stage_round !== 3'd2 || out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_round2: got round=%0d valid=%b want 2/0", stage_round, out_valid); end
    @(negedge clk);
    testsRun++; if (out_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_out_valid: got %b want 1", out_valid); end
    testsRun++; if (out_shares !== exp) begin testsFailed++; $display("[TB] FAIL single_result: got %h want %h", out_shares, exp); end
    testsRun++; if (stage_round !== 3'd0) begin testsFailed++; $display("[TB] FAIL single_hold_round: got %0d want 0", stage_round); end
    @(negedge clk);
    testsRun++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_return: got ready=%b valid=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_hold_stall();
    logic [SW-1:0] exp;
    bit seen;
    exp  = model_eval(12'h123);
    seen = 1'b0;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_shares = 12'h123;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (out_valid) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    testsRun++; if (!seen) begin testsFailed++; $display("[TB] FAIL stall_reach_hold: got timeout want out_valid"); end
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_shares = 12'hFFF;
      @(negedge clk);
      testsRun++;
      if (out_shares !== exp || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL stall_hold_%0d: got shares=%h ready=%b valid=%b want %h/0/1", c, out_shares, in_ready, out_valid, exp);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    testsRun++; if (in_ready !== 1'b1 || stage_in !== exp) begin testsFailed++; $display("[TB] FAIL stall_release: got ready=%b reg=%h want 1/%h", in_ready, stage_in, exp); end
  endtask

  task automatic test_flush();
    logic [SW-1:0] vin;
    bit rose;
    vin  = SW'($urandom) | 12'h001;
    rose = 1'b0;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_shares = vin;
    @(negedge clk);
    in_valid = 1'b0;
    testsRun++; if (stage_round !== 3'd1) begin testsFailed++; $display("[TB] FAIL flush_setup_round: got %0d want 1", stage_round); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    testsRun++; if (in_ready !== 1'b1 || stage_in !== '0 || stage_round !== 3'd0) begin testsFailed++; $display("[TB] FAIL flush_clear: got ready=%b reg=%h round=%0d want 1/000/0", in_ready, stage_in, stage_round); end
    for (int c = 0; c < 4; c++) begin
      if (out_valid) rose = 1'b1;
      @(negedge clk);
    end
    testsRun++; if (rose) begin testsFailed++; $display("[TB] FAIL flush_no_valid: got out_valid=1 want 0"); end
    in_valid = 1'b1; flush = 1'b1; in_shares = 12'h5A5;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    testsRun++; if (in_ready !== 1'b1 || stage_in !== '0) begin testsFailed++; $display("[TB] FAIL flush_beats_accept: got ready=%b reg=%h want 1/000", in_ready, stage_in); end
  endtask

  task automatic test_async_reset();
    logic [SW-1:0] vout;
    bit ok;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_shares = 12'hABC;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    testsRun++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || stage_round !== 3'd0 || stage_in !== '0) begin
      testsFailed++;
      $display("[TB] FAIL async_rst_values: got ready=%b valid=%b round=%0d reg=%h want 1/0/0/000", in_ready, out_valid, stage_round, stage_in);
    end
    @(negedge clk);
    rst = 1'b0;
    do_eval(12'hABC, vout, ok);
    testsRun++; if (!ok || vout !== model_eval(12'hABC)) begin testsFailed++; $display("[TB] FAIL async_rst_fresh: got %h ok=%b want %h", vout, ok, model_eval(12'hABC)); end
  endtask

  task automatic test_remask();
    logic [SW-1:0] vin;
    logic [SW-1:0] vout;
    bit ok;
    randRnd = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      vin = SW'($urandom);
      do_eval(vin, vout, ok);
      testsRun++;
      if (!ok || fold(vout) !== fold(model_eval(vin))) begin
        testsFailed++;
        $display("[TB] FAIL remask_%0d: got fold=%h ok=%b want %h", n, fold(vout), ok, fold(model_eval(vin)));
      end
    end
    randRnd = 1'b0;
    rnd     = '0;
  endtask

  task automatic test_back_to_back();
    logic [SW-1:0] expQ[$];
    logic [SW-1:0] exp;
    int lastAccept;
    int accepts;
    int outs;
    lastAccept = -1; accepts = 0; outs = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (out_valid) begin
        outs++;
        exp = (expQ.size() > 0) ? expQ.pop_front() : '0;
        testsRun++; if (out_shares !== exp) begin testsFailed++; $display("[TB] FAIL b2b_result_%0d: got %h want %h", outs, out_shares, exp); end
      end
      in_valid  = 1'b1;
      in_shares = SW'($urandom);
      if (in_ready) begin
        expQ.push_back(model_eval(in_shares));
        accepts++;
        if (lastAccept >= 0) begin
          testsRun++;
          if (cyc - lastAccept != ROUNDS+2) begin testsFailed++; $display("[TB] FAIL b2b_interval: got %0d want %0d", cyc - lastAccept, ROUNDS+2); end
        end
        lastAccept = cyc;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < ROUNDS+4 && expQ.size() > 0; k++) begin
      if (out_valid) begin
        outs++;
        exp = expQ.pop_front();
        testsRun++; if (out_shares !== exp) begin testsFailed++; $display("[TB] FAIL b2b_drain_%0d: got %h want %h", outs, out_shares, exp); end
      end
      @(negedge clk);
    end
    testsRun++; if (outs != accepts || accepts < 9) begin testsFailed++; $display("[TB] FAIL b2b_count: got outs=%0d accepts=%0d want equal and >=9", outs, accepts); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_shares = '0; out_ready = 1'b0;
    rnd = '0; randRnd = 1'b0;
    test_reset();
    test_single();
    test_hold_stall();
    test_flush();
    test_async_reset();
`ifdef SBOX_TI_REMASK_EN
    test_remask();
`endif
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
